// File: rtl/execute_mc.sv
// Execute stage: single-cycle ALU pass-through plus an iterative RV64M/RV32M
// multiply/divide unit feeding the EX/MA pipeline register.
module execute_mc #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1,
  parameter int CTL_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             stall,
  input  logic             valid_in,
  input  logic             md_en,
  input  logic [2:0]       md_func,
  input  logic             md_word,
  input  logic [XLEN-1:0]  pc,
  input  logic [4:0]       rd,
  input  logic [XLEN-1:0]  data1,
  input  logic [XLEN-1:0]  data2,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [CTL_W-1:0] ctl_in,
  output logic             busy,
  output logic             valid_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       rd_out,
  output logic [XLEN-1:0]  result_out,
  output logic [XLEN-1:0]  data2_out,
  output logic [CTL_W-1:0] ctl_out
);

  localparam int N_FULL = XLEN / UNROLL;
  localparam int N_WORD = 32 / UNROLL;
  localparam int CNT_W  = $clog2(N_FULL) + 1;
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(N_FULL - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Issue-time operand decode (magnitudes, signs, short-circuit cases).
  logic            issue_word, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, issue;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;

  always_comb begin
    issue_word = (XLEN == 64) && md_word;
    a_sgn      = (md_func != 3'd3) && (md_func != 3'd5) && (md_func != 3'd7);
    b_sgn      = a_sgn && (md_func != 3'd2);
    a_ext      = data1;
    b_ext      = data2;
    if (issue_word) begin
      a_ext = a_sgn ? sext32(data1[31:0]) : XLEN'(data1[31:0]);
      b_ext = b_sgn ? sext32(data2[31:0]) : XLEN'(data2[31:0]);
    end
    a_neg    = a_sgn && a_ext[XLEN-1];
    b_neg    = b_sgn && b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    min_neg  = issue_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = md_func[2] && (b_ext == '0);
    div_ovf  = md_func[2] && a_sgn && (a_ext == min_neg) && (b_ext == '1);
    issue    = (state == S_IDLE) && valid_in && md_en && !clear;
  end

  // Latched operation. Multiply: acc += opa (shifted left) for each set bit
  // of opb (shifted right). Divide: acc is the partial remainder, opa the
  // divisor, opb shifts the dividend out and the quotient in.
  logic [2:0]          func_q;
  logic                word_q, neg_q, neg_r, spec_q;
  logic [2*XLEN-1:0]   acc_q, opa_q, acc_it, opa_it;
  logic [XLEN-1:0]     opb_q, opb_it;
  logic [XLEN:0]       rem;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     pc_q, d2_q;
  logic [4:0]          rd_q;
  logic [CTL_W-1:0]    ctl_q;

  always_comb begin
    acc_it = acc_q;
    opa_it = opa_q;
    opb_it = opb_q;
    rem    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (func_q[2]) begin
        rem    = {acc_it[XLEN-1:0], opb_it[XLEN-1]};
        opb_it = {opb_it[XLEN-2:0], 1'b0};
        if (rem >= {1'b0, opa_it[XLEN-1:0]}) begin
          rem       = rem - {1'b0, opa_it[XLEN-1:0]};
          opb_it[0] = 1'b1;
        end
        acc_it = {{XLEN{1'b0}}, rem[XLEN-1:0]};
      end else begin
        if (opb_it[0]) acc_it = acc_it + opa_it;
        opa_it = {opa_it[2*XLEN-2:0], 1'b0};
        opb_it = {1'b0, opb_it[XLEN-1:1]};
      end
    end
  end

  // Handshake: busy high means upstream holds the EX inputs; the EX
  // instruction is consumed on any edge where busy is low.
  logic done_iter;
  always_comb begin
    state_nx  = state;
    done_iter = spec_q || (cnt_q == (word_q ? LAST_WORD : LAST_FULL));
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = valid_in && md_en;
        if (issue) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (clear)          state_nx = S_IDLE;
        else if (done_iter) state_nx = S_DONE;
      end
      S_DONE: begin
        busy = stall;
        if (clear || !stall) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q <= '0; word_q <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; spec_q <= 1'b0;
      acc_q  <= '0; opa_q  <= '0;   opb_q <= '0;   cnt_q <= '0;
      pc_q   <= '0; rd_q   <= '0;   d2_q  <= '0;   ctl_q <= '0;
    end else if (issue) begin
      func_q <= md_func;
      word_q <= issue_word;
      pc_q   <= pc;
      rd_q   <= rd;
      d2_q   <= data2;
      ctl_q  <= ctl_in;
      cnt_q  <= '0;
      spec_q <= div_zero || div_ovf;
      neg_q  <= (a_neg ^ b_neg) && !div_zero && !div_ovf;
      neg_r  <= a_neg && !div_zero && !div_ovf;
      acc_q  <= '0;
      opa_q  <= '0;
      if (!md_func[2]) begin
        opa_q <= {{XLEN{1'b0}}, a_mag};
        opb_q <= b_mag;
      end else if (div_zero) begin
        acc_q <= {{XLEN{1'b0}}, a_ext};
        opb_q <= '1;
      end else if (div_ovf) begin
        opb_q <= a_ext;
      end else begin
        opa_q <= {{XLEN{1'b0}}, b_mag};
        opb_q <= issue_word ? (a_mag << (XLEN - 32)) : a_mag;
      end
    end else if (state == S_RUN) begin
      if (!spec_q) begin
        acc_q <= acc_it;
        opa_q <= opa_it;
        opb_q <= opb_it;
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sign fix-up and result selection, evaluated while in DONE.
  logic [2*XLEN-1:0] mul_p;
  logic [XLEN-1:0]   raw, m_result;
  always_comb begin
    mul_p = neg_q ? -acc_q : acc_q;
    case (func_q)
      3'd0:       raw = mul_p[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       raw = mul_p[2*XLEN-1:XLEN];
      3'd4, 3'd5: raw = neg_q ? -opb_q : opb_q;
      default:    raw = neg_r ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    endcase
    m_result = word_q ? sext32(raw[31:0]) : raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0; pc_out <= '0; rd_out <= '0;
      result_out <= '0; data2_out <= '0; ctl_out <= '0;
    end else if (clear) begin
      valid_out <= 1'b0; pc_out <= '0; rd_out <= '0;
      result_out <= '0; data2_out <= '0; ctl_out <= '0;
    end else if (stall) begin
      valid_out <= valid_out;
    end else if ((state == S_IDLE) && valid_in && !md_en) begin
      valid_out <= 1'b1; pc_out <= pc; rd_out <= rd;
      result_out <= alu_result; data2_out <= data2; ctl_out <= ctl_in;
    end else if (state == S_DONE) begin
      valid_out <= 1'b1; pc_out <= pc_q; rd_out <= rd_q;
      result_out <= m_result; data2_out <= d2_q; ctl_out <= ctl_q;
    end else begin
      valid_out <= 1'b0; pc_out <= '0; rd_out <= '0;
      result_out <= '0; data2_out <= '0; ctl_out <= '0;
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Randomised scoreboard bench for execute_mc against an arithmetic reference
// model of the RV64M rules.
module tb_execute_mc;
  localparam int XLEN   = 64;
  localparam int UNROLL = 1;
  localparam int CTL_W  = 8;
  localparam int PW     = XLEN + 5 + XLEN + XLEN + CTL_W;

  logic             clk, rst_n, clear, stall, valid_in, md_en, md_word;
  logic [2:0]       md_func;
  logic [XLEN-1:0]  pc, data1, data2, alu_result;
  logic [4:0]       rd;
  logic [CTL_W-1:0] ctl_in;
  logic             busy, valid_out;
  logic [XLEN-1:0]  pc_out, result_out, data2_out;
  logic [4:0]       rd_out;
  logic [CTL_W-1:0] ctl_out;

  execute_mc #(.XLEN(XLEN), .UNROLL(UNROLL), .CTL_W(CTL_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stall(stall),
    .valid_in(valid_in), .md_en(md_en), .md_func(md_func), .md_word(md_word),
    .pc(pc), .rd(rd), .data1(data1), .data2(data2), .alu_result(alu_result),
    .ctl_in(ctl_in), .busy(busy), .valid_out(valid_out), .pc_out(pc_out),
    .rd_out(rd_out), .result_out(result_out), .data2_out(data2_out),
    .ctl_out(ctl_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_md(input logic [2:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, p;
    logic [31:0]  a32, b32, r32;
    logic signed [31:0] s_a32, s_b32;
    longint       s_a, s_b;
    logic [63:0]  r;
    logic         as, bs;
    as = (f == 0) || (f == 1) || (f == 2) || (f == 4) || (f == 6);
    bs = (f == 0) || (f == 1) || (f == 4) || (f == 6);
    if (w) begin
      a32 = a[31:0]; b32 = b[31:0]; s_a32 = a32; s_b32 = b32;
      r32 = a32 * b32;
      if (f == 4 || f == 6) begin
        if (b32 == 0)                                  r32 = (f == 4) ? 32'hFFFF_FFFF : a32;
        else if (a32 == 32'h8000_0000 && b32 == '1)    r32 = (f == 4) ? a32 : 32'h0;
        else if (f == 4)                               r32 = s_a32 / s_b32;
        else                                           r32 = s_a32 % s_b32;
      end else if (f == 5 || f == 7) begin
        if (b32 == 0)    r32 = (f == 5) ? 32'hFFFF_FFFF : a32;
        else if (f == 5) r32 = a32 / b32;
        else             r32 = a32 % b32;
      end
      return {{32{r32[31]}}, r32};
    end
    s_a = a; s_b = b;
    sa = as ? {{64{a[63]}}, a} : {64'b0, a};
    sb = bs ? {{64{b[63]}}, b} : {64'b0, b};
    p  = sa * sb;
    case (f)
      3'd0:    r = p[63:0];
      3'd1, 3'd2, 3'd3: r = p[127:64];
      3'd4, 3'd6: begin
        if (b == 0)                                          r = (f == 4) ? '1 : a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1)   r = (f == 4) ? a : 64'h0;
        else if (f == 4)                                     r = s_a / s_b;
        else                                                 r = s_a % s_b;
      end
      default: begin
        if (b == 0)      r = (f == 5) ? '1 : a;
        else if (f == 5) r = a / b;
        else             r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int run_cycles(input logic [2:0] f, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = (f == 4 || f == 6) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (f[2] && (zero || ovf)) return 1;
    return (w ? 32 : XLEN) / UNROLL;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 6))
      0:       return 64'h0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'($signed(32'($urandom_range(0, 40)) - 32'sd20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [PW-1:0] got, exp;
    if (rst_n) begin
      got = {pc_out, rd_out, result_out, data2_out, ctl_out};
      checks++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got result=%h rd=%0d required no output", result_out, rd_out);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL exma_fields got pc=%h rd=%0d res=%h d2=%h ctl=%h required pc=%h rd=%0d res=%h d2=%h ctl=%h",
                     pc_out, rd_out, result_out, data2_out, ctl_out,
                     exp[PW-1 -: 64], exp[PW-65 -: 5], exp[PW-70 -: 64], exp[PW-134 -: 64], exp[CTL_W-1:0]);
          end
        end
      end else if (got !== '0) begin
        failures++;
        $display("FAIL bubble_fields got pc=%h rd=%0d res=%h required all zero", pc_out, rd_out, result_out);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1 so consecutive calls issue back-to-back.
  task automatic run_op(input logic md, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] alu_v,
                        input logic [4:0] rdv, input int stall_len, input int clear_at);
    int busy_cyc, exp_n, exp_busy;
    logic [63:0] res, pcv;
    logic [CTL_W-1:0] ctlv;
    pcv   = {$urandom, $urandom} & ~64'h3;
    ctlv  = CTL_W'($urandom);
    res   = md ? ref_md(f, w, a, b) : alu_v;
    exp_n = md ? run_cycles(f, w, a, b) : 0;
    exp_busy = md ? exp_n + 1 + stall_len : 0;
    valid_in = 1'b1; md_en = md; md_func = f; md_word = w;
    data1 = a; data2 = b; alu_result = alu_v; pc = pcv; rd = rdv; ctl_in = ctlv;
    if (clear_at == 0) exp_q.push_back({pcv, rdv, res, b, ctlv});
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      if (busy_cyc >= 300) begin
        checks++; failures++;
        $display("FAIL busy_timeout busy still high after %0d cycles", busy_cyc);
        break;
      end
      busy_cyc++;
      @(posedge clk); #1;
      if (clear_at > 0 && busy_cyc == clear_at) begin
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; valid_in = 1'b0; md_en = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0) begin
          failures++;
          $display("FAIL clear_flush got busy=%0b valid_out=%0b required 0 0", busy, valid_out);
        end
        @(posedge clk); #1;
        return;
      end
      if (md && stall_len > 0 && busy_cyc == exp_n + 1) stall = 1'b1;
      else if (stall && busy_cyc == exp_n + 1 + stall_len) stall = 1'b0;
    end
    stall = 1'b0;
    checks++;
    if (busy_cyc != exp_busy) begin
      failures++;
      $display("FAIL busy_cycles func=%0d word=%0b got %0d required %0d", f, w, busy_cyc, exp_busy);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; md_en = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL result_latency func=%0d got valid_out=%0b required 1", f, valid_out);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if ({busy, valid_out, pc_out, rd_out, result_out, data2_out, ctl_out} !== '0) begin
      failures++;
      $display("FAIL %s got busy=%0b valid=%0b rd=%0d res=%h required all zero",
               tag, busy, valid_out, rd_out, result_out);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic md, w;
    logic [2:0] f;
    int t, stall_len;
    rst_n = 1'b0; clear = 1'b0; stall = 1'b0; valid_in = 1'b0; md_en = 1'b0;
    md_func = '0; md_word = 1'b0; pc = '0; rd = '0; data1 = '0; data2 = '0;
    alu_result = '0; ctl_in = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset_state");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 3'd0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 64'h1234, 5'd5, 0, 0);
    run_op(1, 3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, 5'd3, 0, 0);
    run_op(1, 3'd3, 0, '1, 64'd2, 0, 5'd4, 0, 0);
    run_op(1, 3'd4, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 5'd6, 0, 0);
    run_op(1, 3'd6, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 5'd7, 0, 0);
    run_op(1, 3'd5, 0, 64'd12345, 64'd0, 0, 5'd8, 0, 0);
    run_op(1, 3'd4, 0, 64'h8000_0000_0000_0000, '1, 0, 5'd9, 0, 0);
    run_op(1, 3'd6, 0, 64'h8000_0000_0000_0000, '1, 0, 5'd10, 0, 0);
    run_op(1, 3'd4, 1, 64'hFFFF_FFFF_8000_0000, 64'd1, 0, 5'd11, 0, 0);
    run_op(1, 3'd0, 1, 64'h7FFF_FFFF, 64'd2, 0, 5'd12, 0, 0);
    run_op(1, 3'd0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 5'd13, 3, 0);
    run_op(1, 3'd0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 5'd14, 0, 11);
    run_op(1, 3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, 5'd15, 0, 0);

    // Asynchronous reset in the middle of a multiply.
    valid_in = 1'b1; md_en = 1'b1; md_func = 3'd0; md_word = 1'b0;
    data1 = {$urandom, $urandom}; data2 = {$urandom, $urandom};
    repeat (20) @(posedge clk);
    #1 valid_in = 1'b0; md_en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_state("reset_mid_run");
    @(negedge clk) rst_n = 1'b1;
    #1 check_reset_state("reset_release");
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      md = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      if (w) begin
        t = $urandom_range(0, 4);
        f = (t == 0) ? 3'd0 : 3'(t + 3);
      end else begin
        f = 3'($urandom_range(0, 7));
      end
      stall_len = (md && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_op(md, f, w, rand_op(), rand_op(), {$urandom, $urandom},
             5'($urandom_range(1, 31)), stall_len, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised next-generation execute stage; sits between decode/forwarding and memory access.
- Passes single-cycle ALU results through the EX/MA pipeline register unchanged.
- Adds an iterative multi-cycle RV64M/RV32M multiply/divide path that stalls the upstream pipeline via `busy`.
- Carries PC, rd, store data and an opaque control bundle into the EX/MA register.

Parameters:
- XLEN, 64, datapath width; legal values 32 and 64.
- UNROLL, 1, bits retired per iteration; must divide 32.
- CTL_W, 8, width of the opaque control bundle (io ops) passed through to MA.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  flush: abort in-flight op, load bubble into EX/MA
- stall  in  1  downstream stall; EX/MA register holds
- valid_in  in  1  instruction present in EX
- md_en  in  1  instruction is an M-extension op
- md_func  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- md_word  in  1  W-variant (XLEN=64 only; ignored when XLEN=32)
- pc  in  XLEN  instruction PC
- rd  in  5  destination register
- data1, data2  in  XLEN  forwarded operands
- alu_result  in  XLEN  single-cycle ALU/CSR result
- ctl_in  in  CTL_W  control bundle
- busy  out  1  combinational; upstream must hold EX inputs while high
- valid_out  out  1  EX/MA valid
- pc_out  out  XLEN  EX/MA PC
- rd_out  out  5  EX/MA rd
- result_out  out  XLEN  EX/MA result
- data2_out  out  XLEN  EX/MA store data
- ctl_out  out  CTL_W  EX/MA control bundle

Behaviour:
- Reset: all registered outputs are 0, FSM is IDLE, iteration counter is 0.
- FSM states:
  - IDLE: on `valid_in & md_en & !clear`, latch operands, func, word, pc, rd, data2 and ctl, then go to RUN.
  - RUN: retire UNROLL bits per cycle. After N = (word ? 32 : XLEN)/UNROLL iterations, go to DONE.
  - DONE: go to IDLE on the first cycle with `!stall`.
- busy = (IDLE & valid_in & md_en) | RUN | (DONE & stall).
  - busy is low in DONE when `!stall`, so upstream advances on the same edge EX/MA loads.
- Latency: issue edge, then N RUN cycles, then DONE. result_out is valid after the DONE edge, i.e. N+2 edges after the issue cycle begins. XLEN=64, UNROLL=1, non-W: 66.
- Multiply uses shift-add on magnitudes with a sign fix-up.
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits, signed×signed / signed×unsigned / unsigned×unsigned.
- Divide uses restoring division on magnitudes.
  - Quotient sign is the XOR of operand signs; remainder takes the dividend's sign.
- Divide by zero short-circuits to DONE after 1 RUN cycle:
  - quotient = all ones;
  - remainder = dividend.
- Signed overflow (most-negative ÷ −1) short-circuits to DONE after 1 RUN cycle:
  - quotient = dividend;
  - remainder = 0.
- W variants:
  - Operands use the low 32 bits; signed ops sign-extend them, unsigned ops zero-extend them.
  - The 32-bit result is sign-extended to XLEN.
- The latched copy is used throughout RUN; input changes during RUN are ignored.
- EX/MA register, per edge, in priority order:
  1. clear → bubble (valid_out=0, rd_out=0, others 0).
  2. stall → hold.
  3. Non-M valid_in with FSM IDLE → load alu_result and the pass-through fields.
  4. FSM in DONE → load the M result and the latched fields.
  5. Otherwise (busy in IDLE-issue or RUN, or no valid_in) → bubble.
- clear mid-RUN or in DONE: FSM returns to IDLE on that edge, the result is discarded, and busy is low in the next cycle.
- clear in the issue cycle: no capture.
- Back-to-back M ops: the second one issues in the cycle after DONE's advancing edge. No overlap.

Test Plan:
- Reset: rst_n low mid-RUN → busy=0 immediately after release, all outputs 0, FSM IDLE.
- ALU pass-through: valid_in=1, md_en=0, alu_result=0x1234, rd=5 → next edge valid_out=1, rd_out=5, result_out=0x1234, busy=0 throughout.
- MUL: data1=7, data2=−3, UNROLL=1 → busy high 65 cycles, result_out=0xFFFFFFFFFFFFFFEB; MULHU of 0xFFFFFFFFFFFFFFFF×2 → 0x1.
- DIV/REM: DIV −7/2 → 0xFFFFFFFFFFFFFFFD; REM −7/2 → 0xFFFFFFFFFFFFFFFF.
  - DIVU x/0 → all ones in 3 edges.
  - DIV 0x8000000000000000/−1 → 0x8000000000000000.
  - REM of that case → 0.
- DIVW: data1=0xFFFFFFFF_80000000, data2=0x1 → 0xFFFFFFFF80000000, busy high 33 cycles; MULW 0x7FFFFFFF×2 → 0xFFFFFFFFFFFFFFFE.
- Stall/clear: stall asserted in DONE for 3 cycles → busy and EX/MA both hold, result appears on release; clear at RUN iteration 10 → bubble, busy=0 next cycle, a new MUL issues correctly.
